// File: rtl/scan_bar_monitor.sv
// scan_bar_monitor: receiving end of the bouncing-bar scanner.
// Samples the bar pattern, decodes the lit position, tracks sweep
// direction, counts end-point bounces and flags illegal patterns/steps.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     synchronous active-low reset
//   bar         scanner pattern, bit WIDTH-1 = left end, bit 0 = right end
//   sample_en   take a sample on this edge
//   pos         index of lit bit from the last one-hot sample
//   pos_valid   last sample was exactly one-hot
//   dir         sweep direction, 1 = toward bit WIDTH-1
//   locked      LOCK_CNT consecutive legal transitions, no error since
//   bounce_cnt  end-point reversals while locked (wraps)
//   err         one-cycle pulse on an illegal sample/transition
//   err_cnt     illegal events since reset (saturates)
module scan_bar_monitor #(
    parameter int unsigned WIDTH    = 18,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] bar,
    input  logic             sample_en,
    output logic [4:0]       pos,
    output logic             pos_valid,
    output logic             dir,
    output logic             locked,
    output logic [7:0]       bounce_cnt,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int unsigned PW = 5;
    localparam int unsigned LW = 4;
    localparam int unsigned CW = 8;

    localparam logic [PW-1:0] POS_TOP  = PW'(WIDTH - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC     = 3'd1,
        TRACK_DN = 3'd2,
        TRACK_UP = 3'd3,
        DWELL_LO = 3'd4,
        DWELL_HI = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   prev, prev_nxt;
    logic [LW-1:0]   lock_cnt, lock_cnt_nxt;
    logic [PW-1:0]   pos_nxt;
    logic            pos_valid_nxt;
    logic            dir_nxt;
    logic            locked_nxt;
    logic [CW-1:0]   bounce_cnt_nxt;
    logic            err_nxt;
    logic [CW-1:0]   err_cnt_nxt;

    logic [PW-1:0]   p;
    logic            one_hot;
    logic            all_zero;
    logic            step_dn;
    logic            step_up;
    logic            legal;
    logic            illegal;
    logic            bounce;
    state_t          tgt;
    logic [LW-1:0]   lock_inc;

    // Decode: index of the lit bit and pattern classification.
    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bar[i]) begin
                p = PW'(i);
            end
        end
        all_zero = (bar == '0);
        one_hot  = !all_zero && ((bar & (bar - WIDTH'(1))) == '0);
        // End guards keep prev-1 / prev+1 from wrapping.
        step_dn  = (prev != '0) && (p == prev - PW'(1));
        step_up  = (prev != POS_TOP) && (p == prev + PW'(1));
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt      = state;
        prev_nxt       = prev;
        lock_cnt_nxt   = lock_cnt;
        pos_nxt        = pos;
        pos_valid_nxt  = pos_valid;
        dir_nxt        = dir;
        locked_nxt     = locked;
        bounce_cnt_nxt = bounce_cnt;
        err_nxt        = 1'b0;
        err_cnt_nxt    = err_cnt;
        legal          = 1'b0;
        illegal        = 1'b0;
        bounce         = 1'b0;
        tgt            = state;
        lock_inc       = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LW'(1);

        if (sample_en) begin
            pos_valid_nxt = one_hot;
            if (one_hot) begin
                pos_nxt = p;
            end

            case (state)
                IDLE: begin
                    if (one_hot) begin
                        state_nxt = SYNC;
                        prev_nxt  = p;
                    end else if (!all_zero) begin
                        illegal = 1'b1;
                    end
                end
                SYNC: begin
                    if (!one_hot) begin
                        illegal = 1'b1;
                    end else if (step_dn) begin
                        legal = 1'b1;
                        tgt   = (p == '0) ? DWELL_LO : TRACK_DN;
                    end else if (step_up) begin
                        legal = 1'b1;
                        tgt   = (p == POS_TOP) ? DWELL_HI : TRACK_UP;
                    end else if (p == prev && p == '0) begin
                        legal = 1'b1;
                        tgt   = TRACK_UP;
                    end else if (p == prev && p == POS_TOP) begin
                        legal = 1'b1;
                        tgt   = TRACK_DN;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                TRACK_DN: begin
                    if (one_hot && step_dn) begin
                        legal = 1'b1;
                        tgt   = (p == '0) ? DWELL_LO : TRACK_DN;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                TRACK_UP: begin
                    if (one_hot && step_up) begin
                        legal = 1'b1;
                        tgt   = (p == POS_TOP) ? DWELL_HI : TRACK_UP;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                DWELL_LO: begin
                    if (one_hot && p == '0) begin
                        legal  = 1'b1;
                        bounce = 1'b1;
                        tgt    = TRACK_UP;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                DWELL_HI: begin
                    if (one_hot && p == POS_TOP) begin
                        legal  = 1'b1;
                        bounce = 1'b1;
                        tgt    = TRACK_DN;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            if (legal) begin
                state_nxt    = tgt;
                prev_nxt     = p;
                dir_nxt      = (tgt == TRACK_UP) || (tgt == DWELL_HI);
                lock_cnt_nxt = lock_inc;
                locked_nxt   = (lock_inc == LOCK_MAX);
                // Only bounces seen with lock already held are counted.
                if (bounce && locked) begin
                    bounce_cnt_nxt = bounce_cnt + CW'(1);
                end
            end

            if (illegal) begin
                err_nxt      = 1'b1;
                err_cnt_nxt  = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CW'(1);
                lock_cnt_nxt = '0;
                locked_nxt   = 1'b0;
                // Resynchronise on a usable one-hot sample, else start over.
                if (one_hot) begin
                    state_nxt = SYNC;
                    prev_nxt  = p;
                end else begin
                    state_nxt = IDLE;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            prev       <= '0;
            lock_cnt   <= '0;
            pos        <= '0;
            pos_valid  <= 1'b0;
            dir        <= 1'b0;
            locked     <= 1'b0;
            bounce_cnt <= '0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            lock_cnt   <= lock_cnt_nxt;
            pos        <= pos_nxt;
            pos_valid  <= pos_valid_nxt;
            dir        <= dir_nxt;
            locked     <= locked_nxt;
            bounce_cnt <= bounce_cnt_nxt;
            err        <= err_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_scan_bar_monitor.sv
// tb_scan_bar_monitor: directed scenarios for scan_bar_monitor.
// Stimulus pushes the expected output set for every edge into a queue;
// the monitor pops and compares one entry per clock edge.
module tb_scan_bar_monitor;

    logic        clock;
    logic        reset_n;
    logic [17:0] bar;
    logic        sample_en;
    logic [4:0]  pos;
    logic        pos_valid;
    logic        dir;
    logic        locked;
    logic [7:0]  bounce_cnt;
    logic        err;
    logic [7:0]  err_cnt;

    typedef struct packed {
        logic [4:0] pos;
        logic       pv;
        logic       dir;
        logic       lk;
        logic [7:0] bc;
        logic       err;
        logic [7:0] ec;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];

    // Expected output values, maintained by the stimulus.
    logic [4:0] e_pos;
    logic       e_pv;
    logic       e_dir;
    logic       e_lk;
    logic [7:0] e_bc;
    logic       e_err;
    logic [7:0] e_ec;

    int n_checks = 0;
    int n_fail   = 0;

    scan_bar_monitor #(.WIDTH(18), .LOCK_CNT(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bar        (bar),
        .sample_en  (sample_en),
        .pos        (pos),
        .pos_valid  (pos_valid),
        .dir        (dir),
        .locked     (locked),
        .bounce_cnt (bounce_cnt),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: one expected entry per edge, checked just after the edge.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() != 0) begin
            obs_t  e;
            obs_t  g;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            g = {pos, pos_valid, dir, locked, bounce_cnt, err, err_cnt};
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got pos=%0d pv=%0b dir=%0b locked=%0b bounce=%0d err=%0b err_cnt=%0d, required pos=%0d pv=%0b dir=%0b locked=%0b bounce=%0d err=%0b err_cnt=%0d",
                         t, g.pos, g.pv, g.dir, g.lk, g.bc, g.err, g.ec,
                         e.pos, e.pv, e.dir, e.lk, e.bc, e.err, e.ec);
            end
        end
    end

    task automatic drive(input logic rn, input logic [17:0] b, input logic en, input string tag);
        @(negedge clock);
        reset_n   = rn;
        bar       = b;
        sample_en = en;
        exp_q.push_back({e_pos, e_pv, e_dir, e_lk, e_bc, e_err, e_ec});
        tag_q.push_back(tag);
    endtask

    function automatic logic [17:0] bit_of(input int idx);
        logic [17:0] one;
        one = 18'd1;
        return one << idx;
    endfunction

    // Enabled sample, optionally followed by a disabled cycle that must hold.
    task automatic step(input logic [17:0] b, input string tag, input bit half);
        drive(1'b1, b, 1'b1, tag);
        if (half) begin
            drive(1'b1, b, 1'b0, {tag, "_hold"});
        end
    endtask

    task automatic do_reset();
        e_pos = '0; e_pv = 1'b0; e_dir = 1'b0; e_lk = 1'b0;
        e_bc  = '0; e_err = 1'b0; e_ec = '0;
        repeat (3) drive(1'b0, 18'h20000, 1'b1, "reset");
    endtask

    // Blank, sync at bit 17, sweep down, then nb bounces each followed by
    // a full traverse to the opposite end.
    task automatic sweep(input int nb, input bit half);
        int  trans;
        bit  at_lo;
        trans = 0;
        e_err = 1'b0;
        e_pv  = 1'b0;
        step(18'h0, "sw_blank", half);
        e_pos = 5'd17; e_pv = 1'b1;
        step(bit_of(17), "sw_sync", half);
        for (int i = 16; i >= 0; i--) begin
            trans++;
            e_pos = 5'(i); e_dir = 1'b0; e_lk = (trans >= 4);
            step(bit_of(i), "sw_down", half);
        end
        for (int b = 1; b <= nb; b++) begin
            at_lo = (b % 2) == 1;
            trans++;
            e_dir = at_lo;
            e_bc  = e_bc + 8'd1;
            e_lk  = 1'b1;
            step(at_lo ? bit_of(0) : bit_of(17), "sw_bounce", half);
            for (int k = 1; k <= 17; k++) begin
                e_pos = at_lo ? 5'(k) : 5'(17 - k);
                step(at_lo ? bit_of(k) : bit_of(17 - k), "sw_travel", half);
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        bar       = '0;
        sample_en = 1'b0;

        // Reset holds everything at zero, then first sample syncs at 17.
        do_reset();
        e_pos = 5'd17; e_pv = 1'b1;
        drive(1'b1, 18'h20000, 1'b1, "reset_release");

        // Full legal sweep with two bounces.
        do_reset();
        sweep(2, 1'b0);

        // Same sweep at half rate, then garbage while disabled.
        do_reset();
        sweep(2, 1'b1);
        repeat (3) drive(1'b1, 18'h3FFFF, 1'b0, "garbage_gated");

        // Skip error while locked in TRACK_DN, then relock.
        do_reset();
        e_pv = 1'b0;
        step(18'h0, "skip_blank", 1'b0);
        e_pos = 5'd17; e_pv = 1'b1;
        step(bit_of(17), "skip_sync", 1'b0);
        for (int i = 16; i >= 9; i--) begin
            e_pos = 5'(i); e_lk = (17 - i) >= 4;
            step(bit_of(i), "skip_down", 1'b0);
        end
        e_pos = 5'd7; e_err = 1'b1; e_ec = 8'd1; e_lk = 1'b0;
        step(bit_of(7), "skip_err", 1'b0);
        e_err = 1'b0;
        for (int i = 6; i >= 3; i--) begin
            e_pos = 5'(i); e_lk = (i == 3);
            step(bit_of(i), "skip_relock", 1'b0);
        end

        // Illegal multi-hot in TRACK_UP, plus both SYNC same-end cases.
        do_reset();
        e_pos = 5'd0; e_pv = 1'b1;
        step(bit_of(0), "ill_sync0", 1'b0);
        e_dir = 1'b1;
        step(bit_of(0), "ill_same0", 1'b0);
        e_pos = 5'd1;
        step(bit_of(1), "ill_up1", 1'b0);
        e_pos = 5'd2;
        step(bit_of(2), "ill_up2", 1'b0);
        e_pv = 1'b0; e_err = 1'b1; e_ec = 8'd1;
        step(18'h00003, "ill_multi", 1'b0);
        e_err = 1'b0;
        step(18'h0, "ill_zero", 1'b0);
        repeat (2) drive(1'b1, 18'h3FFFF, 1'b0, "ill_gated");
        e_pos = 5'd17; e_pv = 1'b1;
        step(bit_of(17), "ill_sync17", 1'b0);
        e_dir = 1'b0;
        step(bit_of(17), "ill_same17", 1'b0);
        e_pos = 5'd16;
        step(bit_of(16), "ill_dn16", 1'b0);

        // err_cnt saturation.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            e_pv = 1'b0; e_err = 1'b1;
            e_ec = (e_ec == 8'hFF) ? 8'hFF : e_ec + 8'd1;
            step(18'h00003, "sat_multi", 1'b0);
            e_err = 1'b0;
            step(18'h0, "sat_zero", 1'b0);
        end

        // bounce_cnt wrap after 260 locked bounces.
        do_reset();
        sweep(260, 1'b0);

        @(posedge clock);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
